mem_responder: RTL and testbench

- Word-addressed main-memory model on the RAM side of the cache-to-RAM bus.
- Accepts the cache's address, tri-state data bus, read/write and chip-enable outputs.
- Services each request after a parameterized number of clock edges and flags completion on odv.
- Serves as the cache's backing store in simulation and in the system top level.

---
 rtl/mem_responder.sv | 92 +++++++++
 tb/tb_mem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed RAM-side memory model with fixed service latency
// Optional: define MEM_ZERO_EN to clear the whole array when clr is asserted.
module mem_responder #(
    parameter int d_width = 8,
    parameter int a_width = 8,
    parameter int latency = 3
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [a_width-1:0] addr_in,
    inout  wire  [d_width-1:0] data,
    input  logic               rw_in,
    input  logic               ce_in,
    output logic               odv
);
    localparam int depth = 2 ** a_width;
    localparam logic [2:0] lat_init = 3'(latency);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [2:0]         timer;
    logic [a_width-1:0] lat_addr;
    logic               lat_rw;
    logic [d_width-1:0] wdata;
    logic [d_width-1:0] rdata;
    logic [d_width-1:0] mem [depth];

    logic same_req;
    logic new_req;
    logic mem_we;

    // Any change of address or direction while a request is held starts a fresh request.
    assign same_req = ce_in && (addr_in == lat_addr) && (rw_in == lat_rw);
    assign new_req  = ce_in && ((state == IDLE) || !same_req);
    assign mem_we   = (state == BUSY) && same_req && (timer == 3'd1) && !lat_rw;

    assign data = (state == DONE && lat_rw && ce_in && rw_in) ? rdata : {d_width{1'bz}};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            odv      <= 1'b0;
            timer    <= 3'd0;
            lat_addr <= '0;
            lat_rw   <= 1'b0;
            wdata    <= '0;
            rdata    <= '0;
        end else if (!ce_in) begin
            state <= IDLE;
            odv   <= 1'b0;
        end else if (new_req) begin
            state    <= BUSY;
            odv      <= 1'b0;
            timer    <= lat_init;
            lat_addr <= addr_in;
            lat_rw   <= rw_in;
            if (!rw_in) begin
                wdata <= data;
            end
        end else if (state == BUSY) begin
            if (timer == 3'd1) begin
                state <= DONE;
                odv   <= 1'b1;
                if (lat_rw) begin
                    rdata <= mem[lat_addr];
                end
            end else begin
                timer <= timer - 3'd1;
            end
        end
    end

`ifdef MEM_ZERO_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[lat_addr] <= wdata;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[lat_addr] <= wdata;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder at latency 3 and latency 1
module tb_mem_responder;
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       rw = 1'b1;
    logic       ce0 = 1'b0;
    logic       ce1 = 1'b0;
    logic       tb_en = 1'b0;
    logic [7:0] tb_drv = 8'h00;
    wire  [7:0] data;
    wire        odv0;
    wire        odv1;
    int         sel = 0;
    int         errors = 0;
    int         checks = 0;

`ifdef MEM_ZERO_EN
    localparam logic [7:0] after_rst = 8'h00;
`else
    localparam logic [7:0] after_rst = 8'h5A;
`endif

    typedef struct {
        int         lat;
        bit         rd;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    assign data = tb_en ? tb_drv : 8'bz;

    always #5 clk = ~clk;

    mem_responder #(.d_width(8), .a_width(8), .latency(3)) u0 (
        .clk(clk), .clr(clr), .addr_in(addr), .data(data),
        .rw_in(rw), .ce_in(ce0), .odv(odv0)
    );

    mem_responder #(.d_width(8), .a_width(8), .latency(1)) u1 (
        .clk(clk), .clr(clr), .addr_in(addr), .data(data),
        .rw_in(rw), .ce_in(ce1), .odv(odv1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_odv();
        return (sel != 0) ? odv1 : odv0;
    endfunction

    // An undriven bus follows whatever the bench puts on it; a DUT driver would corrupt it.
    task automatic probe_z(input string tag);
        logic       old_en;
        logic [7:0] old_drv;
        logic [7:0] a;
        logic [7:0] b;
        old_en  = tb_en;
        old_drv = tb_drv;
        tb_en   = 1'b1;
        tb_drv  = 8'h00;
        #1 a = data;
        tb_drv = 8'hFF;
        #1 b = data;
        tb_en  = old_en;
        tb_drv = old_drv;
        #1;
        check(tag, {16'h0, a, b}, 32'h00FF);
    endtask

    task automatic drive_req(input logic [7:0] a, input logic r, input logic [7:0] wd,
                             input logic [7:0] expval);
        addr = a;
        rw   = r;
        if (!r) begin
            tb_en  = 1'b1;
            tb_drv = wd;
        end else begin
            tb_en = 1'b0;
        end
        if (sel != 0) ce1 = 1'b1;
        else ce0 = 1'b1;
        sb.push_back('{(sel != 0) ? 1 : 3, r, expval});
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        check({tag, "_e0_odv"}, {31'h0, cur_odv()}, 32'h0);
        n = 0;
        while (!cur_odv() && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (!cur_odv()) probe_z({tag, "_busy_z"});
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, n, e.lat);
            check({tag, "_odv"}, {31'h0, cur_odv()}, 32'h1);
            if (e.rd) begin
                tb_en = 1'b0;
                #1;
                check({tag, "_rdata"}, {24'h0, data}, {24'h0, e.val});
            end else begin
                probe_z({tag, "_wr_z"});
            end
        end
    endtask

    task automatic idle(input string tag);
        ce0   = 1'b0;
        ce1   = 1'b0;
        tb_en = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_idle_odv"}, {31'h0, cur_odv()}, 32'h0);
        probe_z({tag, "_idle_z"});
    endtask

    initial begin
        #2;
        check("rst_odv0", {31'h0, odv0}, 32'h0);
        check("rst_odv1", {31'h0, odv1}, 32'h0);
        @(negedge clk);
        probe_z("rst_z");
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;

        drive_req(8'h10, 1'b0, 8'h5A, 8'h00);
        wait_done("wr5a");
        idle("wr5a");

        drive_req(8'h10, 1'b1, 8'h00, 8'h5A);
        wait_done("rd5a");
        idle("rd5a_drop");

        addr   = 8'h10;
        rw     = 1'b0;
        tb_en  = 1'b1;
        tb_drv = 8'hFF;
        ce0    = 1'b1;
        @(posedge clk);
        #1;
        check("abort_e0_odv", {31'h0, odv0}, 32'h0);
        ce0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("abort_odv", {31'h0, odv0}, 32'h0);
        end
        tb_en = 1'b0;
        drive_req(8'h10, 1'b1, 8'h00, 8'h5A);
        wait_done("rd_after_abort");
        idle("rd_after_abort");

        drive_req(8'h11, 1'b0, 8'h33, 8'h00);
        wait_done("wr33");
        idle("wr33");
        drive_req(8'h10, 1'b1, 8'h00, 8'h5A);
        wait_done("rd10");
        drive_req(8'h11, 1'b1, 8'h00, 8'h33);
        wait_done("rd11_switch");
        idle("rd11_switch");

        drive_req(8'h10, 1'b1, 8'h00, 8'h5A);
        wait_done("rd_pre_rst");
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("rst_done_odv", {31'h0, odv0}, 32'h0);
        probe_z("rst_done_z");
        @(negedge clk);
        clr = 1'b1;
        ce0 = 1'b0;
        @(posedge clk);
        #1;

        addr   = 8'h10;
        rw     = 1'b0;
        tb_en  = 1'b1;
        tb_drv = 8'hAA;
        ce0    = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("rst_busy_odv", {31'h0, odv0}, 32'h0);
        probe_z("rst_busy_z");
        @(negedge clk);
        clr   = 1'b1;
        ce0   = 1'b0;
        tb_en = 1'b0;
        @(posedge clk);
        #1;
        drive_req(8'h10, 1'b1, 8'h00, after_rst);
        wait_done("rd_after_rst");
        idle("rd_after_rst");
`ifdef MEM_ZERO_EN
        drive_req(8'h80, 1'b1, 8'h00, 8'h00);
        wait_done("rd_zeroed");
        idle("rd_zeroed");
`endif

        sel = 1;
        drive_req(8'h05, 1'b0, 8'h3C, 8'h00);
        wait_done("l1_wr");
        idle("l1_wr");
        drive_req(8'h05, 1'b1, 8'h00, 8'h3C);
        wait_done("l1_rd");
        idle("l1_rd");

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
